cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller; the receiving end of the exception signals raised by the fetch, decode, execute and memory stages.
- Sits beside the M stage. Takes the merged exception flag, ExcCode, victim PC and branch-delay flag, plus external hardware interrupts.
- Decides whether to take a trap and drives the flush/redirect request.
- Holds SR, Cause, EPC and PRId, serves mfc0/mtc0, and supplies EPC for eret.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, redirect target exported on handler_pc.
- PRID_VAL, 32'h2024_0007, constant read from PRId.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rd_addr  in  5  CP0 register index for mfc0
- rdata  out  32  read data for rd_addr (combinational)
- wr_addr  in  5  CP0 register index for mtc0
- wdata  in  32  mtc0 write data
- we  in  1  mtc0 write enable (M-stage mtc0)
- vpc  in  32  PC of the M-stage instruction
- bd  in  1  M-stage instruction is in a branch delay slot
- exc_valid  in  1  M-stage instruction carries an exception
- exc_code  in  5  ExcCode of that exception (`AdEL, `AdES, `RI, `Ov, `Syscall)
- hw_int  in  6  external interrupt lines, level-sensitive
- exl_clr  in  1  eret retiring in the M stage
- req  out  1  take trap this cycle: flush F..M, redirect to handler_pc
- handler_pc  out  32  equals HANDLER_ADDR
- epc_out  out  32  eret target

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - SR, Cause and EPC are all 0.
  - Therefore req=0 (IE=0), and epc_out=0 unless a bypass is active.
- SR (index 12):
  - IM=[15:10], EXL=[1], IE=[0].
  - All other bits read 0 and ignore writes.
- Cause (index 13):
  - BD=[31], IP=[15:10], ExcCode=[6:2]; other bits 0.
  - Read-only to mtc0.
- EPC (index 14): full 32-bit, read/write.
- PRId (index 15): returns PRID_VAL; writes ignored.
- Reads:
  - Any other rd_addr returns 0.
  - rdata shows register state before this cycle's edge. There is no mtc0→mfc0 bypass; the pipeline stalls or orders these instructions.
- Trap decision (combinational, same cycle as inputs):
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
  - exc_req = exc_valid & ~SR.EXL.
  - req = int_req | exc_req.
- Priority: interrupt beats a synchronous exception in the same cycle.
- On a posedge with req=1:
  - SR.EXL←1.
  - Cause.ExcCode←(int_req ? 5'd0 : exc_code).
  - Cause.BD←bd.
  - EPC←(bd ? vpc−4 : vpc), 32-bit wrap modulo 2^32.
- Cause.IP←hw_int every cycle, regardless of req or EXL.
- mtc0:
  - A write occurs on a posedge with we=1 and req=0.
  - If req=1 the write is suppressed, because the writing instruction is being flushed.
- eret (exl_clr=1):
  - SR.EXL←0 at the posedge.
  - If req=1 in the same cycle, trap entry wins and EXL stays 1. In practice this cannot occur, because req needs EXL=0.
- epc_out:
  - Equals wdata when we=1 and wr_addr=14 (mtc0 EPC immediately followed by eret); otherwise equals the EPC register.
- mtc0 to SR in the same cycle as exl_clr: the written value applies first, then EXL is cleared.
- Pending interrupt while EXL=1:
  - Held off.
  - req rises in the first cycle after EXL clears, provided the masked line is still high. Interrupts are level-sensitive with no latching.
- vpc alignment: not checked here. A bad PC arrives already encoded as exc_code=`AdEL.

Decomposition:
- Extend the shared parameters.v with:
  - CP0 register indices (12–15).
  - ExcCode constants Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
  - SR/Cause bit-field positions.
- A single module. No sub-module is natural; the trap arbiter is about 5 lines of logic.

Test Plan:
- Reset, then read 12/13/14 → all 0. Read 15 → PRID_VAL. req=0 while hw_int=6'h3F.
- mtc0 SR=32'h0000_FC01, then hw_int[2]=1 → req=1 that cycle. Next cycle: Cause.ExcCode=0, EXL=1, EPC=vpc (e.g. 0x3010), req=0.
- EXL=0, exc_valid=1, exc_code=`AdEL, vpc=0x0000_3002, bd=1 → req=1. Then EPC=0x0000_2FFE, Cause=0x8000_0010 (BD=1, ExcCode=4).
- Same cycle interrupt+exception (IE=1, IM[0]=1, hw_int[0]=1, exc_code=`Ov) → ExcCode=0.
- Trap cycle with we=1, wr_addr=14, wdata=0x1234 → EPC gets the victim PC, not 0x1234. mtc0 EPC=0x3100 with we held → epc_out=0x3100 the same cycle.
- EXL=1, hw_int pending, exl_clr pulse → req stays 0 during the pulse and rises in the next cycle. Assert rst while EXL=1 → SR=0 and req=0 the next cycle.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: register indices, ExcCode values and SR/Cause field positions.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam int unsigned SR_IE_BIT    = 0;
  localparam int unsigned SR_EXL_BIT   = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_IM_HI     = 15;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD_BIT = 31;

  // A delay-slot victim restarts at its branch so the branch is re-executed.
  function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic in_bd);
    return in_bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage: trap arbitration plus SR,
// Cause, EPC and PRId with mfc0/mtc0 access and the eret EPC target.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h2024_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rdata,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [31:0] vpc,
  input  logic        bd,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic int_req;
  logic exc_req;

  assign int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_req = exc_valid & ~sr_exl_q;
  assign req     = int_req | exc_req;

  assign handler_pc = HANDLER_ADDR;
  // Lets an eret directly behind an mtc0 EPC see the new target.
  assign epc_out    = (we && (wr_addr == CP0_EPC)) ? wdata : epc_q;

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      // Trap entry wins over both the flushed mtc0 and any eret.
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? EXC_INT : exc_code;
      cause_bd_d  = bd;
      epc_d       = victim_epc(vpc, bd);
    end else begin
      if (we) begin
        if (wr_addr == CP0_SR) begin
          sr_im_d  = wdata[SR_IM_HI:SR_IM_LO];
          sr_exl_d = wdata[SR_EXL_BIT];
          sr_ie_d  = wdata[SR_IE_BIT];
        end else if (wr_addr == CP0_EPC) begin
          epc_d = wdata;
        end
      end
      if (exl_clr) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_addr)
      CP0_SR:    rdata = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
      CP0_CAUSE: rdata = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};
      CP0_EPC:   rdata = epc_q;
      CP0_PRID:  rdata = PRID_VAL;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized traffic
// checked against a register-word level reference model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h2024_0007;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr;
  logic [31:0] rdata;
  logic [4:0]  wr_addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] vpc;
  logic        bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;

  // Reference model: whole architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rdata      (rdata),
    .wr_addr    (wr_addr),
    .wdata      (wdata),
    .we         (we),
    .vpc        (vpc),
    .bd         (bd),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .hw_int     (hw_int),
    .exl_clr    (exl_clr),
    .req        (req),
    .handler_pc (handler_pc),
    .epc_out    (epc_out)
  );

  always #5 clk = ~clk;

  function automatic bit m_int_req();
    return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_req();
    return m_int_req() || (exc_valid && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_out();
    return (we && wr_addr == 5'd14) ? wdata : m_epc;
  endfunction

  task automatic model_edge();
    logic [31:0] ncause;
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      ncause = (m_cause & ~32'h0000_FC00) | (32'(hw_int) << 10);
      if (m_req()) begin
        ncause = (ncause & ~32'h8000_007C) | (32'(bd) << 31)
               | (32'(m_int_req() ? 5'd0 : exc_code) << 2);
        m_epc  = bd ? vpc - 32'd4 : vpc;
        m_sr   = m_sr | 32'd2;
      end else begin
        if (we && wr_addr == 5'd12) m_sr = wdata & SR_MASK;
        if (we && wr_addr == 5'd14) m_epc = wdata;
        if (exl_clr) m_sr = m_sr & ~32'd2;
      end
      m_cause = ncause;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; wr_addr = 0; wdata = 0; exc_valid = 0; exc_code = 0;
    bd = 0; vpc = 0; hw_int = 0; exl_clr = 0; rd_addr = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; wr_addr = a; wdata = d;
    tick();
    we = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); hw_int = 6'h3F;
    tick(); tick();
    #1;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req); end
    rst = 0; hw_int = 0;
    tick();
    for (int a = 12; a <= 15; a++) begin
      rd_addr = 5'(a); #1;
      checks++;
      if (rdata !== (a == 15 ? PRID : 32'd0)) begin
        errors++; $display("FAIL reset_read[%0d] got %h want %h", a, rdata, (a == 15 ? PRID : 32'd0));
      end
    end
    checks++;
    if (handler_pc !== HANDLER) begin
      errors++; $display("FAIL handler_pc got %h want %h", handler_pc, HANDLER);
    end
  endtask

  task automatic test_int_entry();
    mtc0(5'd12, 32'h0000_FC01);
    hw_int = 6'b000100; vpc = 32'h0000_3010; #1;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL int_req got %b want 1", req); end
    tick();
    hw_int = 0; #1;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL int_req_after got %b want 0", req); end
    rd_addr = 5'd13; #1;
    checks++;
    if (rdata !== 32'h0000_1000) begin errors++; $display("FAIL int_cause got %h want 00001000", rdata); end
    rd_addr = 5'd12; #1;
    checks++;
    if (rdata !== 32'h0000_FC03) begin errors++; $display("FAIL int_sr got %h want 0000fc03", rdata); end
    rd_addr = 5'd14; #1;
    checks++;
    if (rdata !== 32'h0000_3010) begin errors++; $display("FAIL int_epc got %h want 00003010", rdata); end
  endtask

  task automatic test_exc_bd();
    mtc0(5'd12, 32'h0);
    exc_valid = 1; exc_code = 5'd4; vpc = 32'h0000_3002; bd = 1; #1;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL exc_req got %b want 1", req); end
    tick();
    exc_valid = 0; bd = 0;
    rd_addr = 5'd14; #1;
    checks++;
    if (rdata !== 32'h0000_2FFE) begin errors++; $display("FAIL bd_epc got %h want 00002ffe", rdata); end
    rd_addr = 5'd13; #1;
    checks++;
    if (rdata !== 32'h8000_0010) begin errors++; $display("FAIL bd_cause got %h want 80000010", rdata); end
  endtask

  task automatic test_priority();
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001; exc_valid = 1; exc_code = 5'd12; vpc = 32'h0000_3020; #1;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL prio_req got %b want 1", req); end
    tick();
    exc_valid = 0; hw_int = 0; rd_addr = 5'd13; #1;
    checks++;
    if (rdata[6:2] !== 5'd0) begin errors++; $display("FAIL prio_exccode got %0d want 0", rdata[6:2]); end
  endtask

  task automatic test_trap_vs_mtc0();
    mtc0(5'd12, 32'h0);
    exc_valid = 1; exc_code = 5'd10; vpc = 32'h0000_5000;
    we = 1; wr_addr = 5'd14; wdata = 32'h0000_1234; #1;
    checks++;
    if (epc_out !== 32'h0000_1234) begin errors++; $display("FAIL bypass_trap got %h want 00001234", epc_out); end
    tick();
    exc_valid = 0; we = 0; rd_addr = 5'd14; #1;
    checks++;
    if (rdata !== 32'h0000_5000) begin errors++; $display("FAIL trap_epc got %h want 00005000", rdata); end
    we = 1; wr_addr = 5'd14; wdata = 32'h0000_3100; #1;
    checks++;
    if (epc_out !== 32'h0000_3100) begin errors++; $display("FAIL bypass_epc got %h want 00003100", epc_out); end
    tick();
    we = 0; #1;
    checks++;
    if (epc_out !== 32'h0000_3100) begin errors++; $display("FAIL epc_written got %h want 00003100", epc_out); end
  endtask

  task automatic test_eret();
    mtc0(5'd12, 32'h0000_0403);
    hw_int = 6'b000001; #1;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL eret_hold got %b want 0", req); end
    exl_clr = 1; #1;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL eret_pulse got %b want 0", req); end
    tick();
    exl_clr = 0; #1;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL eret_rise got %b want 1", req); end
    tick();
    rst = 1;
    tick();
    rst = 0; rd_addr = 5'd12; #1;
    checks++;
    if (rdata !== 32'd0 || req !== 1'b0) begin
      errors++; $display("FAIL rst_exl sr=%h req=%b want 0/0", rdata, req);
    end
    hw_int = 0;
    // mtc0 SR together with eret: the write lands, then EXL is cleared.
    we = 1; wr_addr = 5'd12; wdata = 32'h0000_0403; exl_clr = 1;
    tick();
    we = 0; exl_clr = 0; #1;
    checks++;
    if (rdata !== 32'h0000_0401) begin errors++; $display("FAIL mtc0_eret sr got %h want 00000401", rdata); end
  endtask

  task automatic test_random();
    logic [4:0] codes [5] = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      rd_addr   = 5'($urandom_range(10, 17));
      we        = ($urandom_range(0, 3) == 0);
      wr_addr   = 5'($urandom_range(11, 16));
      wdata     = $urandom;
      vpc       = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bd        = 1'($urandom_range(0, 1));
      exc_valid = ($urandom_range(0, 7) == 0);
      exc_code  = codes[$urandom_range(0, 4)];
      hw_int    = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      exl_clr   = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (req !== 1'(m_req())) begin
        errors++; $display("FAIL rnd_req[%0d] got %b want %b", i, req, m_req());
      end
      checks++;
      if (rdata !== m_rdata(rd_addr)) begin
        errors++; $display("FAIL rnd_rdata[%0d] addr %0d got %h want %h", i, rd_addr, rdata, m_rdata(rd_addr));
      end
      checks++;
      if (epc_out !== m_epc_out()) begin
        errors++; $display("FAIL rnd_epc_out[%0d] got %h want %h", i, epc_out, m_epc_out());
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    rst = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_int_entry();
    test_exc_bd();
    test_priority();
    test_trap_vs_mtc0();
    test_eret();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
